digit_scan_sequencer: RTL and testbench
=======================================

Name: digit_scan_sequencer

Overview:
Parametrised display-multiplex sequencer for N-digit seven-segment displays. Divides the system clock to a programmable per-digit dwell time. Walks a digit index 0..NUM_DIGITS-1 with an optional blanking gap between digits to suppress ghosting. Drives the digit-select index, a one-hot anode bus and frame/digit strobes to the segment-data mux and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
DIV_WIDTH, 19, width of dwell-divisor input and dwell counter
BLANK_CYCLES, 16, clock cycles all anodes are off between digits (0 = no gap)
ANODE_ACTIVE_LOW, 1, 1 = anode bus inverted at output (active-low pins)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  1 = scanning, 0 = go idle with all anodes off
divisor  input  DIV_WIDTH  dwell cycles per digit, values <2 treated as 2
digitSel  output  IDXW=max(1,$clog2(NUM_DIGITS))  index of digit currently driven
anode  output  NUM_DIGITS  one-hot digit drive, polarity per ANODE_ACTIVE_LOW
blank  output  1  1 when no digit is driven (IDLE or BLANK)
digitTick  output  1  one-cycle pulse on the last ON cycle of every digit
frameTick  output  1  one-cycle pulse coincident with digitTick of digit NUM_DIGITS-1

Behaviour:
- Registers: state {IDLE, ON, BLANK}, idx[IDXW], cnt[DIV_WIDTH], divLat[DIV_WIDTH].
- Reset (reset=0, async): state=IDLE, idx=0, cnt=0, divLat=2. Outputs: digitSel=0, blank=1, anode all inactive (all 1s if ANODE_ACTIVE_LOW, else 0), digitTick=0, frameTick=0.
- Outputs are decoded combinationally from registers only. No input-to-output combinational paths.
- anode (pre-polarity) = one-hot(idx) when state==ON, else 0. blank = (state!=ON). digitSel = idx always.
- IDLE: on an edge with enable=1, go to ON, cnt=0, divLat=max(divisor,2). The anode is visible in the cycle after that edge.
- ON: cnt increments each cycle. The last ON cycle is cnt==divLat-1, so ON lasts exactly divLat cycles.
  - digitTick=1 during that last cycle. frameTick=1 during it also when idx==NUM_DIGITS-1.
  - At the end edge: if BLANK_CYCLES>0, go to BLANK with cnt=0. Otherwise go directly to ON for the next digit.
- BLANK: lasts exactly BLANK_CYCLES cycles. At its end edge, go to ON with cnt=0.
- Digit advance: idx increments on every entry into the next ON (from ON or BLANK), wrapping NUM_DIGITS-1 -> 0. Non-power-of-2 NUM_DIGITS must never produce idx>=NUM_DIGITS.
- divisor is sampled into divLat only at each ON entry. A mid-digit change affects the next digit only.
- enable=0 sampled on any edge: state=IDLE, cnt=0, idx held, no tick pulses in the following cycle. Re-enable resumes at the held idx, not at 0.
- cnt is compared against divLat-1 or BLANK_CYCLES-1 using DIV_WIDTH arithmetic; no overflow path. divisor=all-ones is legal: dwell = 2^DIV_WIDTH-1.
- Asynchronous reset asserted mid-digit or mid-blank forces the reset values immediately, without waiting for a clock edge. Deassertion is synchronised upstream.
- Full scan period = NUM_DIGITS*(divLat+BLANK_CYCLES) cycles, with divisor constant. Default refresh example: 50 MHz, divisor=100000, 4 digits, blank 16 -> ~125 Hz frame.

Decomposition:
- Shared display package holds the state enum typedef (SCAN_IDLE, SCAN_ON, SCAN_BLANK) and the minimum-divisor constant 2.
- Package also holds an IDXW helper function, reused by the segment-data mux.
- Natural sub-module: scan_onehot_decoder (idx, en -> NUM_DIGITS one-hot, with polarity parameter). The decoder is reused by the LED-matrix row driver.
- Dwell and blank counting share one counter in the top level; no separate divider instance.

Test Plan:
1. Reset, then enable=1, divisor=5, BLANK_CYCLES=2, NUM_DIGITS=4 -> anodes 0001,0010,0100,1000 each active 5 cycles, separated by 2 blank cycles. frameTick every 28 cycles; digitTick on the 5th ON cycle.
2. BLANK_CYCLES=0, divisor=3, NUM_DIGITS=3 -> digits change back-to-back every 3 cycles, blank never 1 after first ON. idx sequence 0,1,2,0, never 3.
3. divisor=0 and divisor=1 -> each digit dwells exactly 2 cycles. divisor changed 7->4 mid-digit -> current digit still 7 cycles, next digit 4.
4. enable dropped during digit 2 ON -> next cycle blank=1, anodes inactive, no ticks, digitSel stays 2. enable raised -> digit 2 ON for full divLat.
5. reset pulled low mid-BLANK with clk stopped -> outputs reach reset values (anode 1111 for active-low, digitSel=0) without a clock edge. After release + enable -> digit 0 first.
6. ANODE_ACTIVE_LOW=0 vs 1 on identical stimulus -> anode buses are bitwise complements; all other outputs identical.

Source files
------------

// File: rtl/digit_scan_sequencer_pkg.sv
// Shared display definitions: scan FSM states, minimum dwell, and the
// digit-index width helper used by the sequencer and the segment-data mux.
package digit_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_ON    = 2'd1,
    SCAN_BLANK = 2'd2
  } scan_state_t;

  localparam int MIN_DIVISOR = 2;

  // Index width for n digits; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_sequencer_onehot.sv
// Index-to-one-hot decoder with selectable output polarity.
// Also used by the LED-matrix row driver.
module scan_onehot_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int IDXW       = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [IDXW-1:0]       idx,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] onehot
);

  logic [NUM_DIGITS-1:0] raw;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    assign raw[gi] = en && (idx == IDXW'(gi));
  end

  assign onehot = ACTIVE_LOW ? ~raw : raw;

endmodule

// File: rtl/digit_scan_sequencer.sv
// Seven-segment digit multiplex sequencer: per-digit dwell, optional
// blanking gap, one-hot anode drive and digit/frame strobes.
module digit_scan_sequencer
  import digit_scan_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DIV_WIDTH        = 19,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1,
  localparam int IDXW            = idx_width(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic [IDXW-1:0]       digitSel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  blank,
  output logic                  digitTick,
  output logic                  frameTick
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV    = DIV_WIDTH'(MIN_DIVISOR);
  localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDXW-1:0]      IDX_LAST   = IDXW'(NUM_DIGITS - 1);

  scan_state_t          state;
  logic [IDXW-1:0]      idx;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_lat;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [IDXW-1:0]      idx_next;
  logic                 on_last;
  logic                 blank_last;
  logic                 digit_on;

  assign div_clamped = (divisor < MIN_DIV) ? MIN_DIV : divisor;
  // Explicit wrap keeps non-power-of-two digit counts in range.
  assign idx_next    = (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
  assign digit_on    = (state == SCAN_ON);
  assign on_last     = digit_on && (cnt == div_lat - ONE);
  assign blank_last  = (state == SCAN_BLANK) && (cnt == BLANK_LAST);

  // One counter serves both the dwell and the blanking gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SCAN_IDLE;
      idx     <= '0;
      cnt     <= '0;
      div_lat <= MIN_DIV;
    end else if (!enable) begin
      state <= SCAN_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          state   <= SCAN_ON;
          cnt     <= '0;
          div_lat <= div_clamped;
        end
        SCAN_ON: begin
          if (on_last) begin
            cnt <= '0;
            if (BLANK_CYCLES > 0) begin
              state <= SCAN_BLANK;
            end else begin
              idx     <= idx_next;
              div_lat <= div_clamped;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        SCAN_BLANK: begin
          if (blank_last) begin
            state   <= SCAN_ON;
            cnt     <= '0;
            idx     <= idx_next;
            div_lat <= div_clamped;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

  assign digitSel  = idx;
  assign blank     = !digit_on;
  assign digitTick = on_last;
  assign frameTick = on_last && (idx == IDX_LAST);

  scan_onehot_decoder #(
    .NUM_DIGITS(NUM_DIGITS),
    .IDXW      (IDXW),
    .ACTIVE_LOW(ANODE_ACTIVE_LOW != 0)
  ) u_anode_dec (
    .idx   (idx),
    .en    (digit_on),
    .onehot(anode)
  );

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Directed bench for digit_scan_sequencer: three instances share stimulus
// (4 digits/blank 2 active-low, same with active-high, 3 digits/no blank).
module tb_digit_scan_sequencer;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [18:0] divisor = 19'd5;

  logic [1:0] sel_a, sel_b, sel_c;
  logic [3:0] anode_a, anode_b;
  logic [2:0] anode_c;
  logic       blank_a, blank_b, blank_c;
  logic       dt_a, dt_b, dt_c;
  logic       ft_a, ft_b, ft_c;

  int total = 0;
  int bad = 0;

  digit_scan_sequencer #(.NUM_DIGITS(4), .DIV_WIDTH(19), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .digitSel(sel_a), .anode(anode_a), .blank(blank_a), .digitTick(dt_a), .frameTick(ft_a));

  digit_scan_sequencer #(.NUM_DIGITS(4), .DIV_WIDTH(19), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .digitSel(sel_b), .anode(anode_b), .blank(blank_b), .digitTick(dt_b), .frameTick(ft_b));

  digit_scan_sequencer #(.NUM_DIGITS(3), .DIV_WIDTH(19), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .digitSel(sel_c), .anode(anode_c), .blank(blank_c), .digitTick(dt_c), .frameTick(ft_c));

  // Gated clock so the async-reset test can freeze all edges.
  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    enable = 1'b0;
    step;
    step;
    reset = 1'b1;
  endtask

  task automatic measure_on(output int n);
    n = 0;
    while (blank_a == 1'b0 && n < 1000) begin
      n++;
      step;
    end
  endtask

  task automatic wait_on;
    int k;
    k = 0;
    while (blank_a && k < 100) begin
      step;
      k++;
    end
    total++;
    if (blank_a !== 1'b0) begin
      bad++;
      $display("FAIL wait_on: got blank=%b after %0d cycles want 0", blank_a, k);
    end
  endtask

  task automatic test_reset;
    logic [8:0] got;
    reset = 1'b0;
    enable = 1'b0;
    #2;
    got = {sel_a, anode_a, blank_a, dt_a, ft_a};
    total++;
    if (got !== 9'b00_1111_100) begin
      bad++;
      $display("FAIL reset_a: got %h want %h", got, 9'b00_1111_100);
    end
    total++;
    if (anode_b !== 4'b0000) begin
      bad++;
      $display("FAIL reset_b_anode: got %b want 0000", anode_b);
    end
    total++;
    if ({sel_c, anode_c, blank_c} !== 6'b00_111_1) begin
      bad++;
      $display("FAIL reset_c: got %b want 001111", {sel_c, anode_c, blank_c});
    end
    step;
    reset = 1'b1;
    step;
    total++;
    if (blank_a !== 1'b1) begin
      bad++;
      $display("FAIL idle_hold: got blank=%b want 1", blank_a);
    end
    $display("test_reset done, total=%0d", total);
  endtask

  task automatic test_scan_sequence;
    logic [8:0] got, exp;
    logic [3:0] an;
    int cyc, last_frame;
    apply_reset;
    divisor = 19'd5;
    enable = 1'b1;
    cyc = 0;
    last_frame = -1;
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 5; c++) begin
          step;
          cyc++;
          an = 4'b0001;
          an = ~(an << d);
          exp = {2'(d), an, 1'b0, (c == 4), (c == 4 && d == 3)};
          got = {sel_a, anode_a, blank_a, dt_a, ft_a};
          total++;
          if (got !== exp) begin
            bad++;
            $display("FAIL scan f%0d d%0d c%0d: got %h want %h", f, d, c, got, exp);
          end
          if (ft_a) begin
            if (last_frame >= 0) begin
              total++;
              if (cyc - last_frame != 28) begin
                bad++;
                $display("FAIL frame_period: got %0d want 28", cyc - last_frame);
              end
            end
            last_frame = cyc;
          end
        end
        for (int b = 0; b < 2; b++) begin
          step;
          cyc++;
          got = {sel_a, anode_a, blank_a, dt_a, ft_a};
          exp = {2'(d), 4'b1111, 1'b1, 1'b0, 1'b0};
          total++;
          if (got !== exp) begin
            bad++;
            $display("FAIL blank f%0d d%0d b%0d: got %h want %h", f, d, b, got, exp);
          end
        end
      end
    end
    $display("test_scan_sequence done, total=%0d", total);
  endtask

  task automatic test_back_to_back;
    logic [7:0] got, exp;
    logic [2:0] an;
    int d, c;
    apply_reset;
    divisor = 19'd3;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d = (k / 3) % 3;
      c = k % 3;
      step;
      an = 3'b001;
      an = ~(an << d);
      exp = {2'(d), an, 1'b0, (c == 2), (c == 2 && d == 2)};
      got = {sel_c, anode_c, blank_c, dt_c, ft_c};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back k%0d: got %h want %h", k, got, exp);
      end
    end
    $display("test_back_to_back done, total=%0d", total);
  endtask

  task automatic test_min_divisor;
    int n;
    apply_reset;
    divisor = 19'd0;
    enable = 1'b1;
    step;
    measure_on(n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL dwell_div0: got %0d want 2", n);
    end
    divisor = 19'd1;
    wait_on;
    measure_on(n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL dwell_div1: got %0d want 2", n);
    end
    divisor = 19'd7;
    wait_on;
    divisor = 19'd4;
    measure_on(n);
    total++;
    if (n != 7) begin
      bad++;
      $display("FAIL dwell_mid_change_cur: got %0d want 7", n);
    end
    wait_on;
    measure_on(n);
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL dwell_mid_change_next: got %0d want 4", n);
    end
    $display("test_min_divisor done, total=%0d", total);
  endtask

  task automatic test_enable_drop;
    logic [8:0] got;
    int k, n;
    apply_reset;
    divisor = 19'd5;
    enable = 1'b1;
    step;
    k = 0;
    while (!(sel_a == 2'd2 && blank_a == 1'b0) && k < 100) begin
      step;
      k++;
    end
    total++;
    if (sel_a !== 2'd2) begin
      bad++;
      $display("FAIL reach_digit2: got %0d want 2", sel_a);
    end
    step;
    step;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      got = {sel_a, anode_a, blank_a, dt_a, ft_a};
      total++;
      if (got !== 9'b10_1111_100) begin
        bad++;
        $display("FAIL enable_drop i%0d: got %h want %h", i, got, 9'b10_1111_100);
      end
    end
    enable = 1'b1;
    step;
    got = {sel_a, anode_a, blank_a, dt_a, ft_a};
    total++;
    if (got !== 9'b10_1011_000) begin
      bad++;
      $display("FAIL resume_digit2: got %h want %h", got, 9'b10_1011_000);
    end
    measure_on(n);
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL resume_dwell: got %0d want 5", n);
    end
    $display("test_enable_drop done, total=%0d", total);
  endtask

  task automatic test_async_reset;
    logic [8:0] got;
    apply_reset;
    divisor = 19'd5;
    enable = 1'b1;
    repeat (13) step;
    total++;
    if ({sel_a, blank_a} !== 3'b01_1) begin
      bad++;
      $display("FAIL pre_reset_blank: got %b want 011", {sel_a, blank_a});
    end
    clk_run = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    got = {sel_a, anode_a, blank_a, dt_a, ft_a};
    total++;
    if (got !== 9'b00_1111_100) begin
      bad++;
      $display("FAIL async_reset_a: got %h want %h", got, 9'b00_1111_100);
    end
    total++;
    if ({anode_b, anode_c, blank_c} !== 8'b0000_111_1) begin
      bad++;
      $display("FAIL async_reset_bc: got %b want 00001111", {anode_b, anode_c, blank_c});
    end
    #10;
    reset = 1'b1;
    #5;
    clk_run = 1'b1;
    step;
    got = {sel_a, anode_a, blank_a, dt_a, ft_a};
    total++;
    if (got !== 9'b00_1110_000) begin
      bad++;
      $display("FAIL after_reset_digit0: got %h want %h", got, 9'b00_1110_000);
    end
    $display("test_async_reset done, total=%0d", total);
  endtask

  task automatic test_polarity;
    apply_reset;
    divisor = 19'd3;
    enable = 1'b1;
    step;
    total++;
    if (anode_b !== 4'b0001) begin
      bad++;
      $display("FAIL polarity_first: got %b want 0001", anode_b);
    end
    for (int i = 0; i < 30; i++) begin
      total++;
      if (anode_b !== ~anode_a) begin
        bad++;
        $display("FAIL polarity_anode i%0d: got %b want %b", i, anode_b, ~anode_a);
      end
      total++;
      if ({sel_b, blank_b, dt_b, ft_b} !== {sel_a, blank_a, dt_a, ft_a}) begin
        bad++;
        $display("FAIL polarity_other i%0d: got %b want %b", i,
                 {sel_b, blank_b, dt_b, ft_b}, {sel_a, blank_a, dt_a, ft_a});
      end
      step;
    end
    $display("test_polarity done, total=%0d", total);
  endtask

  initial begin
    test_reset;
    test_scan_sequence;
    test_back_to_back;
    test_min_divisor;
    test_enable_drop;
    test_async_reset;
    test_polarity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
